// File: rtl/ps2_key_decoder.sv
// PS/2 Set 2 scancode to ASCII decoder with prefix FSM, modifier tracking and an output FIFO.
// Optional caps-lock tracking is enabled by defining PS2_KEY_DECODER_CAPS_LOCK_EN.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] key_ascii,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       shift_active,
    output logic       caps_lock,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
`ifdef PS2_KEY_DECODER_CAPS_LOCK_EN
    localparam logic [7:0] CODE_CAPS   = 8'h58;
`endif

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    typedef struct packed {
        logic       hit;
        logic [7:0] ascii;
    } map_t;

    // Translate a non-extended make code; hit=0 means the key produces no character.
    function automatic map_t map_code(input logic [7:0] code, input logic upper);
        map_t       m;
        logic [4:0] letter;
        logic       is_letter;
        m         = '0;
        letter    = '0;
        is_letter = 1'b0;
        case (code)
            8'h1C: begin is_letter = 1'b1; letter = 5'd0;  end
            8'h32: begin is_letter = 1'b1; letter = 5'd1;  end
            8'h21: begin is_letter = 1'b1; letter = 5'd2;  end
            8'h23: begin is_letter = 1'b1; letter = 5'd3;  end
            8'h24: begin is_letter = 1'b1; letter = 5'd4;  end
            8'h2B: begin is_letter = 1'b1; letter = 5'd5;  end
            8'h34: begin is_letter = 1'b1; letter = 5'd6;  end
            8'h33: begin is_letter = 1'b1; letter = 5'd7;  end
            8'h43: begin is_letter = 1'b1; letter = 5'd8;  end
            8'h3B: begin is_letter = 1'b1; letter = 5'd9;  end
            8'h42: begin is_letter = 1'b1; letter = 5'd10; end
            8'h4B: begin is_letter = 1'b1; letter = 5'd11; end
            8'h3A: begin is_letter = 1'b1; letter = 5'd12; end
            8'h31: begin is_letter = 1'b1; letter = 5'd13; end
            8'h44: begin is_letter = 1'b1; letter = 5'd14; end
            8'h4D: begin is_letter = 1'b1; letter = 5'd15; end
            8'h15: begin is_letter = 1'b1; letter = 5'd16; end
            8'h2D: begin is_letter = 1'b1; letter = 5'd17; end
            8'h1B: begin is_letter = 1'b1; letter = 5'd18; end
            8'h2C: begin is_letter = 1'b1; letter = 5'd19; end
            8'h3C: begin is_letter = 1'b1; letter = 5'd20; end
            8'h2A: begin is_letter = 1'b1; letter = 5'd21; end
            8'h1D: begin is_letter = 1'b1; letter = 5'd22; end
            8'h22: begin is_letter = 1'b1; letter = 5'd23; end
            8'h35: begin is_letter = 1'b1; letter = 5'd24; end
            8'h1A: begin is_letter = 1'b1; letter = 5'd25; end
            8'h45: m = '{hit: 1'b1, ascii: 8'h30};
            8'h16: m = '{hit: 1'b1, ascii: 8'h31};
            8'h1E: m = '{hit: 1'b1, ascii: 8'h32};
            8'h26: m = '{hit: 1'b1, ascii: 8'h33};
            8'h25: m = '{hit: 1'b1, ascii: 8'h34};
            8'h2E: m = '{hit: 1'b1, ascii: 8'h35};
            8'h36: m = '{hit: 1'b1, ascii: 8'h36};
            8'h3D: m = '{hit: 1'b1, ascii: 8'h37};
            8'h3E: m = '{hit: 1'b1, ascii: 8'h38};
            8'h46: m = '{hit: 1'b1, ascii: 8'h39};
            8'h29: m = '{hit: 1'b1, ascii: 8'h20};
            8'h5A: m = '{hit: 1'b1, ascii: 8'h0D};
            8'h66: m = '{hit: 1'b1, ascii: 8'h08};
            default: m = '0;
        endcase
        if (is_letter) begin
            m.hit   = 1'b1;
            m.ascii = (upper ? 8'h41 : 8'h61) + {3'b000, letter};
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Prefix FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   make_stb;
    logic   break_stb;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        make_stb  = 1'b0;
        break_stb = 1'b0;
        if (byte_valid) begin
            case (state_q)
                IDLE: begin
                    if (byte_in == CODE_EXT)      state_d = EXT;
                    else if (byte_in == CODE_BRK) state_d = BRK;
                    else                          make_stb = 1'b1;
                end
                EXT: begin
                    if (byte_in == CODE_BRK)      state_d = EXT_BRK;
                    else if (byte_in != CODE_EXT) state_d = IDLE;
                end
                BRK: begin
                    if (byte_in != CODE_BRK) begin
                        break_stb = 1'b1;
                        state_d   = IDLE;
                    end
                end
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Modifier tracking (non-extended makes and breaks only)
    // ------------------------------------------------------------------
    logic lshift_q, rshift_q;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lshift_q <= 1'b0;
            rshift_q <= 1'b0;
        end else begin
            if (make_stb && byte_in == CODE_LSHIFT)  lshift_q <= 1'b1;
            if (break_stb && byte_in == CODE_LSHIFT) lshift_q <= 1'b0;
            if (make_stb && byte_in == CODE_RSHIFT)  rshift_q <= 1'b1;
            if (break_stb && byte_in == CODE_RSHIFT) rshift_q <= 1'b0;
        end
    end

    assign shift_active = lshift_q | rshift_q;

`ifdef PS2_KEY_DECODER_CAPS_LOCK_EN
    logic caps_lock_q, caps_held_q;

    // caps_held suppresses toggling on typematic repeats until the key is released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            caps_lock_q <= 1'b0;
            caps_held_q <= 1'b0;
        end else begin
            if (make_stb && byte_in == CODE_CAPS) begin
                if (!caps_held_q) caps_lock_q <= ~caps_lock_q;
                caps_held_q <= 1'b1;
            end
            if (break_stb && byte_in == CODE_CAPS) caps_held_q <= 1'b0;
        end
    end

    assign caps_lock = caps_lock_q;
`else
    assign caps_lock = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Character FIFO
    // ------------------------------------------------------------------
    map_t          mapped;
    logic          push, pop, push_ok, full;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    mem [FIFO_DEPTH];

    assign mapped    = map_code(byte_in, shift_active ^ caps_lock);
    assign push      = make_stb & mapped.hit;
    assign key_valid = (count != '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = key_valid & key_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = push & (~full | pop);
    assign key_ascii = key_valid ? mem[rd_ptr] : 8'h00;

    // NOTE: the storage array has no reset; count alone defines which entries are meaningful.
    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= mapped.ascii;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !push_ok) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: expected characters are queued when bytes are sent
// and compared whenever the decoder hands a character over.
module tb_ps2_key_decoder;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic [7:0] key_ascii;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       shift_active;
    logic       caps_lock;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    ps2_key_decoder #(.FIFO_DEPTH(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .key_ascii    (key_ascii),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .shift_active (shift_active),
        .caps_lock    (caps_lock),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    // Strobe one byte for one cycle; returns #1 after the edge that captured it.
    task automatic send(input logic [7:0] b);
        @(posedge clock);
        #1;
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clock);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
        #1;
        check(tag, exp_q.size(), 0);
    endtask

    // Output monitor: every accepted handshake must match the oldest expected character.
    always @(negedge clock) begin
        if (reset_n && key_valid && key_ready) begin
            if (exp_q.size() != 0) check("char_out", key_ascii, exp_q.pop_front());
            else                   check("spurious_out", 32'(exp_q.size() != 0), 1);
        end
    end

    localparam logic [7:0] FILL_CODES  [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                                               8'h2B, 8'h34, 8'h33, 8'h43};
    localparam logic [7:0] FILL_ASCII  [9] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65,
                                               8'h66, 8'h67, 8'h68, 8'h69};

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", key_valid, 0);
        check("rst_ascii", key_ascii, 8'h00);
        check("rst_shift", shift_active, 0);
        check("rst_caps", caps_lock, 0);
        check("rst_ovf", overflow, 0);
        reset_n = 1'b1;

        // Single make then break: one 'a', valid for exactly one cycle
        exp_q.push_back(8'h61);
        send(8'h1C);
        check("lat_valid", key_valid, 1);
        check("lat_ascii", key_ascii, 8'h61);
        @(posedge clock);
        #1;
        check("lat_popped", key_valid, 0);
        send(8'hF0);
        send(8'h1C);
        check("brk_no_out", key_valid, 0);
        wait_drain("drain_basic");

        // Shift make/break around a letter
        send(8'h12);
        check("shift_on", shift_active, 1);
        exp_q.push_back(8'h41);
        send(8'h1C);
        send(8'hF0);
        check("shift_mid_brk", shift_active, 1);
        send(8'h12);
        check("shift_off", shift_active, 0);
        exp_q.push_back(8'h61);
        send(8'h1C);
        send(8'h59);
        check("rshift_on", shift_active, 1);
        send(8'hF0);
        send(8'h59);
        check("rshift_off", shift_active, 0);
        wait_drain("drain_shift");

        // Caps lock with typematic repeat
        send(8'h58);
`ifdef PS2_KEY_DECODER_CAPS_LOCK_EN
        check("caps_first", caps_lock, 1);
        send(8'h58);
        check("caps_repeat", caps_lock, 1);
        send(8'hF0);
        send(8'h58);
        exp_q.push_back(8'h42);
`else
        check("caps_first", caps_lock, 0);
        send(8'h58);
        check("caps_repeat", caps_lock, 0);
        send(8'hF0);
        send(8'h58);
        exp_q.push_back(8'h62);
`endif
        check("caps_key_no_out", key_valid, 0);
        send(8'h32);
        wait_drain("drain_caps");

        // Extended make/break produce nothing; next plain make decodes normally
        send(8'hE0);
        send(8'h75);
        check("ext_make_none", key_valid, 0);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("ext_brk_none", key_valid, 0);
        exp_q.push_back(8'h30);
        send(8'h45);
        exp_q.push_back(8'h20);
        send(8'h29);
        exp_q.push_back(8'h0D);
        send(8'h5A);
        wait_drain("drain_ext");

        // Overflow: 9 mapped makes into a depth-8 FIFO with no consumer
        key_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(FILL_ASCII[i]);
            send(FILL_CODES[i]);
            if (i == 7) check("ovf_before_drop", overflow, 0);
        end
        check("ovf_set", overflow, 1);
        check("ovf_head", key_ascii, 8'h61);
        key_ready = 1'b1;
        wait_drain("drain_ovf");
        @(posedge clock);
        #1;
        check("ovf_empty", key_valid, 0);
        check("ovf_sticky", overflow, 1);

        // Reset after a break prefix discards the pending break
        send(8'hF0);
        #2 reset_n = 1'b0;
        #10 reset_n = 1'b1;
        check("rst2_ovf", overflow, 0);
        check("rst2_valid", key_valid, 0);
        exp_q.push_back(8'h61);
        send(8'h1C);
        check("rst2_valid_after", key_valid, 1);
        wait_drain("drain_rst");

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
